// File: rtl/fc_neuron_seq_if.sv
// rtl/fc_neuron_seq_if.sv - input beat stream, weight/bias write port and result stream for fc_neuron_seq
interface fc_neuron_seq_if #(
    parameter int WIDTH = 8,
    parameter int IN    = 128,
    parameter int LANES = 4
);
    localparam int AW  = WIDTH*2 + $clog2(IN) + 1;
    localparam int AWD = $clog2(IN+1);

    logic [WIDTH-1:0] x [0:LANES-1];
    logic             in_valid;
    logic             in_ready;
    logic             w_we;
    logic [AWD-1:0]   w_addr;
    logic [WIDTH-1:0] w_data;
    logic [AW-1:0]    z;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output x, in_valid, w_we, w_addr, w_data, out_ready,
        input  in_ready, z, out_valid
    );

    modport slave (
        input  x, in_valid, w_we, w_addr, w_data, out_ready,
        output in_ready, z, out_valid
    );
endinterface

// File: rtl/fc_neuron_seq.sv
// rtl/fc_neuron_seq.sv - sequential fully-connected neuron, LANES MACs per beat, two-stage product/accumulate pipeline
// Optional ReLU on the result when FC_RELU_EN is defined.
module fc_neuron_seq #(
    parameter int WIDTH = 8,
    parameter int IN    = 128,
    parameter int LANES = 4
) (
    input  logic            clk,
    input  logic            rst,
    fc_neuron_seq_if.slave  bus
);
    localparam int AW    = WIDTH*2 + $clog2(IN) + 1;
    localparam int AWD   = $clog2(IN+1);
    localparam int PW    = 2*WIDTH;
    localparam int BEATS = IN / LANES;
    localparam int CW    = $clog2(BEATS+1);
    localparam int IW    = (IN > 1) ? $clog2(IN) : 1;
    localparam logic [AWD-1:0] BIAS_ADDR = AWD'(IN);
    localparam logic [CW-1:0]  LAST_BEAT = CW'(BEATS-1);

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic signed [WIDTH-1:0] w [0:IN-1];
    logic signed [WIDTH-1:0] bias;
    logic signed [PW-1:0]    prod [0:LANES-1];
    logic                    prod_valid;
    logic signed [AW-1:0]    acc;
    logic signed [AW-1:0]    z_r;
    logic                    out_valid_r;

    logic                    accept;
    logic [CW-1:0]           beat_idx;
    logic signed [WIDTH-1:0] wsel [0:LANES-1];
    logic signed [AW-1:0]    psum;
    logic signed [AW-1:0]    final_sum;
    logic signed [AW-1:0]    z_next;

    assign bus.in_ready  = (state == IDLE) ? !bus.w_we : (state == ACC);
    assign bus.z         = z_r;
    assign bus.out_valid = out_valid_r;
    assign accept        = bus.in_valid && bus.in_ready;

    // The first beat is taken from IDLE while cnt still reads 0.
    always_comb begin
        beat_idx = (state == IDLE) ? '0 : cnt;
        for (int k = 0; k < LANES; k++) begin
            wsel[k] = w[IW'(int'(beat_idx)*LANES + k)];
        end
        psum = '0;
        if (prod_valid) begin
            for (int k = 0; k < LANES; k++) begin
                psum = psum + AW'(prod[k]);
            end
        end
        final_sum = acc + psum + AW'(bias);
`ifdef FC_RELU_EN
        z_next = final_sum[AW-1] ? '0 : final_sum;
`else
        z_next = final_sum;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            prod_valid  <= 1'b0;
            z_r         <= '0;
            out_valid_r <= 1'b0;
            bias        <= '0;
            for (int i = 0; i < IN; i++) begin
                w[i] <= '0;
            end
            for (int k = 0; k < LANES; k++) begin
                prod[k] <= '0;
            end
        end else begin
            prod_valid <= accept;
            if (accept) begin
                for (int k = 0; k < LANES; k++) begin
                    prod[k] <= $signed(bus.x[k]) * wsel[k];
                end
            end
            if (prod_valid) begin
                acc <= acc + psum;
            end

            case (state)
                IDLE: begin
                    if (bus.w_we) begin
                        if (bus.w_addr < BIAS_ADDR) begin
                            w[IW'(bus.w_addr)] <= bus.w_data;
                        end else if (bus.w_addr == BIAS_ADDR) begin
                            bias <= bus.w_data;
                        end
                    end
                    if (accept) begin
                        acc   <= '0;
                        cnt   <= CW'(1);
                        state <= (BEATS == 1) ? DRAIN : ACC;
                    end
                end
                ACC: begin
                    if (accept) begin
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST_BEAT) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Retire the last products and fold in the bias in one step.
                    acc         <= final_sum;
                    z_r         <= z_next;
                    out_valid_r <= 1'b1;
                    state       <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        cnt         <= '0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_neuron_seq.sv
// tb/tb_fc_neuron_seq.sv - randomized self-checking bench for fc_neuron_seq against a dot-product reference model
module tb_fc_neuron_seq;
    localparam int W     = 8;
    localparam int IN    = 8;
    localparam int LANES = 2;
    localparam int BEATS = IN / LANES;
    localparam int AW    = 2*W + $clog2(IN) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fc_neuron_seq_if #(.WIDTH(W), .IN(IN), .LANES(LANES)) bus ();

    fc_neuron_seq #(.WIDTH(W), .IN(IN), .LANES(LANES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passed = 0;
    int total  = 0;
    int xv [0:IN-1];
    int wv [0:IN-1];
    int bv;
    logic [AW-1:0] last_z;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic logic [63:0] zexp(input longint v);
        logic [AW-1:0] t;
        t = AW'(v);
        return 64'(t);
    endfunction

    function automatic longint model();
        longint s;
        s = longint'(bv);
        for (int i = 0; i < IN; i++) s += longint'(xv[i]) * longint'(wv[i]);
`ifdef FC_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    task automatic wr(input int addr, input int data);
        bus.w_we   = 1'b1;
        bus.w_addr = 4'(addr);
        bus.w_data = W'(data);
        @(negedge clk);
        bus.w_we = 1'b0;
        if (addr < IN) wv[addr] = data;
        else if (addr == IN) bv = data;
    endtask

    task automatic set_weights(input int wval, input int b);
        for (int i = 0; i < IN; i++) wr(i, wval);
        wr(IN, b);
    endtask

    function automatic int rnd_s8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic send_vector(input int maxgap, input bit acc_write, input bit idle_write, input int hold);
        longint exp;
        for (int b = 0; b < BEATS; b++) begin
            if (b > 0) begin
                repeat ($urandom_range(0, maxgap)) begin
                    bus.in_valid = 1'b0;
                    @(negedge clk);
                end
            end
            for (int k = 0; k < LANES; k++) bus.x[k] = W'(xv[b*LANES+k]);
            bus.in_valid = 1'b1;
            if (idle_write && b == 0) begin
                bus.w_we   = 1'b1;
                bus.w_addr = 4'd0;
                bus.w_data = W'(7);
                #1;
                check("in_ready_idle_write", 64'(bus.in_ready), 64'd0);
                @(negedge clk);
                bus.w_we = 1'b0;
                wv[0] = 7;
            end
            if (acc_write && b == 1) begin
                bus.w_we   = 1'b1;
                bus.w_addr = 4'd0;
                bus.w_data = W'(9);
            end
            #1;
            check("in_ready_beat", 64'(bus.in_ready), 64'd1);
            @(negedge clk);
            bus.w_we = 1'b0;
        end
        bus.in_valid = 1'b0;
        exp = model();
        check("out_valid_drain", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check("out_valid_rise", 64'(bus.out_valid), 64'd1);
        check("z", 64'(bus.z), zexp(exp));
        last_z = bus.z;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_z", 64'(bus.z), zexp(exp));
            check("hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        check("out_valid_drop", 64'(bus.out_valid), 64'd0);
        check("in_ready_after", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.w_we      = 1'b0;
        bus.w_addr    = '0;
        bus.w_data    = '0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < LANES; k++) bus.x[k] = '0;
        for (int i = 0; i < IN; i++) begin xv[i] = 0; wv[i] = 0; end
        bv = 0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_z", 64'(bus.z), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        rst = 1'b0;
        @(negedge clk);

        // weights 1, x = 1..8, plus an out-of-range write that must be ignored
        wr(12, 55);
        set_weights(1, 0);
        for (int i = 0; i < IN; i++) xv[i] = i + 1;
        send_vector(0, 1'b0, 1'b0, 0);
        check("sum_1_to_8", 64'(last_z), zexp(36));

        set_weights(-1, 0);
        for (int i = 0; i < IN; i++) xv[i] = 5;
        send_vector(0, 1'b0, 1'b0, 0);

        set_weights(-128, 127);
        for (int i = 0; i < IN; i++) xv[i] = -128;
        send_vector(0, 1'b0, 1'b0, 0);
        check("max_products", 64'(last_z), zexp(131199));

        // backpressure, then a vector started the cycle after the handshake
        for (int i = 0; i < IN; i++) xv[i] = rnd_s8();
        send_vector(1, 1'b0, 1'b0, 5);
        for (int i = 0; i < IN; i++) xv[i] = rnd_s8();
        send_vector(0, 1'b0, 1'b0, 0);

        // write during ACC is dropped; write in IDLE with in_valid stalls one cycle and lands
        set_weights(3, -4);
        for (int i = 0; i < IN; i++) xv[i] = rnd_s8();
        send_vector(1, 1'b1, 1'b0, 0);
        for (int i = 0; i < IN; i++) xv[i] = rnd_s8();
        send_vector(1, 1'b0, 1'b1, 0);

        // reset after two accepted beats
        set_weights(5, 10);
        for (int k = 0; k < LANES; k++) bus.x[k] = W'(100);
        bus.in_valid = 1'b1;
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_z", 64'(bus.z), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < IN; i++) wv[i] = 0;
        bv = 0;
        for (int i = 0; i < IN; i++) xv[i] = rnd_s8();
        send_vector(0, 1'b0, 1'b0, 0);
        set_weights(1, 0);
        for (int i = 0; i < IN; i++) xv[i] = 2;
        send_vector(0, 1'b0, 1'b0, 0);
        check("after_reset", 64'(last_z), zexp(16));

        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < IN; i++) wr(i, rnd_s8());
            wr(IN, rnd_s8());
            for (int i = 0; i < IN; i++) xv[i] = rnd_s8();
            send_vector(2, 1'b0, 1'b0, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fc_neuron_seq.md
FC_NEURON_SEQ -- requirements
Module: fc_neuron_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8: signed two's-complement bit width of inputs, weights and bias.
REQ-002 SHALL have parameter IN, default 128: inputs per output vector; IN SHALL be a multiple of LANES.
REQ-003 SHALL have parameter LANES, default 4: inputs consumed per accepted beat.
REQ-004 SHALL define localparam AW = WIDTH*2+$clog2(IN)+1 as the accumulator and result width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 x  input  [WIDTH-1:0] x[0:LANES-1]  one beat of signed inputs; lane k holds element beat*LANES+k.
REQ-008 in_valid  input  1  x carries a valid beat.
REQ-009 in_ready  output  1  block accepts a beat this cycle.
REQ-010 w_we  input  1  weight or bias write strobe.
REQ-011 w_addr  input  $clog2(IN+1)  addresses 0..IN-1 select weights; address IN selects bias.
REQ-012 w_data  input  WIDTH  signed weight or bias value.
REQ-013 z  output  AW  signed neuron result.
REQ-014 out_valid  output  1  z is valid.
REQ-015 out_ready  input  1  downstream accepts z.

Function
REQ-016 SHALL use states IDLE, ACC, DRAIN and OUT; reset state is IDLE.
REQ-017 A beat is accepted when in_valid and in_ready are both high in the same cycle.
REQ-018 in_ready SHALL equal !w_we in IDLE, 1 in ACC, and 0 in DRAIN and OUT.
REQ-019 In IDLE, an accepted beat SHALL clear the accumulator, set the beat counter to 1, and move to ACC; IN/LANES==1 SHALL go directly to DRAIN.
REQ-020 Each accepted beat SHALL register LANES signed products x[k]*w[beat*LANES+k] as product stage 1.
REQ-021 Stage 2 SHALL add the sum of the registered products, sign-extended to AW, into the accumulator.
REQ-022 The beat counter SHALL increment per accepted beat; accepting beat IN/LANES-1 SHALL move the block to DRAIN.
REQ-023 A cycle in ACC with in_valid low SHALL insert a bubble and leave the counter and accumulator unchanged.
REQ-024 DRAIN SHALL last exactly one cycle: it retires the final products and adds the sign-extended bias; the block then enters OUT.
REQ-025 out_valid SHALL rise exactly 2 cycles after the last beat is accepted.
REQ-026 z SHALL be the activated accumulator value (see REQ-034) and SHALL be held stable while out_valid is high and out_ready is low.
REQ-027 On out_valid && out_ready, the block SHALL go to IDLE and drop out_valid, and in_ready SHALL be 1 in the next cycle.
REQ-028 A w_we cycle SHALL update its register only in IDLE; writes in ACC, DRAIN or OUT SHALL be ignored.
REQ-029 w_addr values greater than IN SHALL be ignored.
REQ-030 Arithmetic SHALL be exact with no saturation; AW bits SHALL cover IN maximum products plus the bias.

Reset
REQ-031 Asserting rst SHALL immediately force state IDLE, beat counter 0, accumulator 0, product registers 0, z 0, out_valid 0 and in_ready 1.
REQ-032 Asserting rst SHALL immediately clear all weights and the bias to 0.
REQ-033 A reset mid-vector SHALL discard all partial sums; the next vector SHALL carry no residue.

Configuration
REQ-034 With macro FC_RELU_EN defined, z SHALL be 0 when the final sum is negative and the sum otherwise; with it undefined, z SHALL be the signed sum unmodified.

Verification (WIDTH=8, IN=8, LANES=2)
REQ-035 Weights all 1, bias 0, x=1..8 over 4 back-to-back beats -> z=36, out_valid 2 cycles after beat 4.
REQ-036 Weights all -1, bias 0, all x=5 -> z=0 with FC_RELU_EN; z=-40 (AW-bit two's complement) without it.
REQ-037 All x=-128, all weights -128, bias 127 -> z=131199, with no overflow.
REQ-038 out_ready held low 5 cycles after out_valid -> z stable and in_ready 0 throughout; after the handshake, the next vector is accepted on the following cycle.
REQ-039 rst pulsed after 2 accepted beats, then a full vector with weights 1 and x=2 -> z=16.
REQ-040 w_we to address 0 with data 9 during ACC -> weight 0 unchanged, result as if the write never occurred.
REQ-041 w_we in IDLE with in_valid high -> in_ready 0, the write takes effect, and the beat is accepted the next cycle using the new weight.
